// File: rtl/intr_ctrl_if.sv
// -----------------------------------------------------------------------------
// intr_ctrl_if
// Bus and interrupt signals between a CPU/bus master and the interrupt
// controller. The tristate data bus is a separate inout port on intr_ctrl.
//
//   abus   master->slave  BITS  bus address
//   we     master->slave  1     bus write enable
//   flush  master->slave  1     squashes the current bus access
//   src    master->slave  NSRC  level interrupt lines from devices
//   inta   master->slave  1     CPU acknowledge, one-cycle pulse
//   irq    slave->master  1     interrupt request to CPU
//   ivec   slave->master  4     ID of the acknowledged source
// -----------------------------------------------------------------------------
interface intr_ctrl_if #(
    parameter int BITS = 32,
    parameter int NSRC = 4
);
    logic [BITS-1:0] abus;
    logic            we;
    logic            flush;
    logic [NSRC-1:0] src;
    logic            inta;
    logic            irq;
    logic [3:0]      ivec;

    modport master (
        output abus, we, flush, src, inta,
        input  irq, ivec
    );

    modport slave (
        input  abus, we, flush, src, inta,
        output irq, ivec
    );
endinterface

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Priority interrupt controller with edge-detected sources, a memory-mapped
// register block and a three-state request/acknowledge/EOI handshake.
//
//   clk      in     1     rising-edge clock
//   rst      in     1     asynchronous active-high reset
//   bus      slave  -     address, we, flush, sources, inta, irq, ivec
//   dbus_io  inout  BITS  bus data; driven only on a selected read
//
// Register map (byte offsets from BASE):
//   +0  PEND   read / write-1-to-clear
//   +4  MASK   read / write
//   +8  CTRL   bit0 GIE (rw), bit1 EOI (write-only, reads 0)
//   +12 ISRID  read-only: bit4 busy, bits3:0 in-service ID
// -----------------------------------------------------------------------------
module intr_ctrl #(
    parameter int              BITS = 32,
    parameter logic [BITS-1:0] BASE = 32'hF0000800,
    parameter int              NSRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    intr_ctrl_if.slave       bus,
    inout  wire  [BITS-1:0]  dbus_io
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [BITS-1:0] ADDR_PEND  = BASE;
    localparam logic [BITS-1:0] ADDR_MASK  = BASE + BITS'(32'd4);
    localparam logic [BITS-1:0] ADDR_CTRL  = BASE + BITS'(32'd8);
    localparam logic [BITS-1:0] ADDR_ISRID = BASE + BITS'(32'd12);

    state_e          state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] src_prev_q;
    logic            gie_q, gie_d;
    logic [3:0]      id_q, id_d;
    logic [3:0]      ivec_q, ivec_d;
    logic [3:0]      isr_id_q, isr_id_d;
    logic            busy_q, busy_d;
    logic            irq_q;

    logic            sel_pend_s, sel_mask_s, sel_ctrl_s, sel_isrid_s, sel_any_s;
    logic            wr_pend_s, wr_mask_s, wr_ctrl_s;
    logic [15:0]     pend_ext_s, mask_ext_s, ack_ext_s;
    logic            cand_valid_s;
    logic [3:0]      cand_id_s;
    logic            ack_s;
    logic [BITS-1:0] rdata_s;

    // A flushed access selects nothing, so it neither writes nor drives data.
    assign sel_pend_s  = !bus.flush && (bus.abus == ADDR_PEND);
    assign sel_mask_s  = !bus.flush && (bus.abus == ADDR_MASK);
    assign sel_ctrl_s  = !bus.flush && (bus.abus == ADDR_CTRL);
    assign sel_isrid_s = !bus.flush && (bus.abus == ADDR_ISRID);
    assign sel_any_s   = sel_pend_s || sel_mask_s || sel_ctrl_s || sel_isrid_s;

    assign wr_pend_s = sel_pend_s && bus.we;
    assign wr_mask_s = sel_mask_s && bus.we;
    assign wr_ctrl_s = sel_ctrl_s && bus.we;

    // Widen PEND/MASK to the full 16-entry ID space so a 4-bit ID can index them.
    always_comb begin
        pend_ext_s = 16'd0;
        mask_ext_s = 16'd0;
        pend_ext_s[NSRC-1:0] = pend_q;
        mask_ext_s[NSRC-1:0] = mask_q;
    end

    // Priority encoder: lowest pending and unmasked index wins.
    always_comb begin
        cand_valid_s = 1'b0;
        cand_id_s    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_ext_s[i] && mask_ext_s[i]) begin
                cand_valid_s = 1'b1;
                cand_id_s    = 4'(i);
            end else begin
                cand_valid_s = cand_valid_s;
            end
        end
    end

    // Handshake FSM next-state and service bookkeeping.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ivec_d   = ivec_q;
        isr_id_d = isr_id_q;
        busy_d   = busy_q;
        ack_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && cand_valid_s) begin
                    state_d = ST_REQ;
                    id_d    = cand_id_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A withdrawn request takes precedence over a same-cycle INTA.
                if (!pend_ext_s[id_q] || !mask_ext_s[id_q] || !gie_q) begin
                    state_d = ST_IDLE;
                end else if (bus.inta) begin
                    state_d  = ST_SERVICE;
                    ack_s    = 1'b1;
                    ivec_d   = id_q;
                    isr_id_d = id_q;
                    busy_d   = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                // EOI retires the whole ISRID; IVEC keeps the last acknowledged ID.
                if (wr_ctrl_s && dbus_io[1]) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    isr_id_d = 4'd0;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register-file next values; a rising edge beats any same-cycle clear.
    always_comb begin
        ack_ext_s = ack_s ? (16'd1 << id_q) : 16'd0;
        pend_d    = (bus.src & ~src_prev_q)
                  | (pend_q & ~(wr_pend_s ? dbus_io[NSRC-1:0] : {NSRC{1'b0}})
                            & ~ack_ext_s[NSRC-1:0]);
        if (wr_mask_s) begin
            mask_d = dbus_io[NSRC-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (wr_ctrl_s) begin
            gie_d = dbus_io[0];
        end else begin
            gie_d = gie_q;
        end
    end

    // State and register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= {NSRC{1'b0}};
            mask_q     <= {NSRC{1'b0}};
            src_prev_q <= {NSRC{1'b0}};
            gie_q      <= 1'b0;
            id_q       <= 4'd0;
            ivec_q     <= 4'd0;
            isr_id_q   <= 4'd0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            src_prev_q <= bus.src;
            gie_q      <= gie_d;
            id_q       <= id_d;
            ivec_q     <= ivec_d;
            isr_id_q   <= isr_id_d;
            busy_q     <= busy_d;
            irq_q      <= (state_d == ST_REQ);
        end
    end

    // Read data mux, zero-extended to the bus width.
    always_comb begin
        rdata_s = {BITS{1'b0}};
        if (sel_pend_s) begin
            rdata_s[NSRC-1:0] = pend_q;
        end else if (sel_mask_s) begin
            rdata_s[NSRC-1:0] = mask_q;
        end else if (sel_ctrl_s) begin
            rdata_s[0] = gie_q;
        end else if (sel_isrid_s) begin
            rdata_s[4:0] = {busy_q, isr_id_q};
        end else begin
            rdata_s = {BITS{1'b0}};
        end
    end

    assign dbus_io  = (sel_any_s && !bus.we) ? rdata_s : {BITS{1'bz}};
    assign bus.irq  = irq_q;
    assign bus.ivec = ivec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Directed scenarios plus a randomized run checked against a behavioural model
// of the controller kept in plain bit arrays and flags.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

    localparam int          BITS    = 32;
    localparam int          NSRC    = 4;
    localparam logic [31:0] BASE    = 32'hF0000800;
    localparam logic [31:0] A_PEND  = BASE;
    localparam logic [31:0] A_MASK  = BASE + 32'd4;
    localparam logic [31:0] A_CTRL  = BASE + 32'd8;
    localparam logic [31:0] A_ISRID = BASE + 32'd12;
    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;

    intr_ctrl_if #(.BITS(BITS), .NSRC(NSRC)) bus ();

    // Pulled-up bus: an undriven DBUS reads as all ones.
    tri1  [31:0] dbus;
    logic        tb_drive;
    logic [31:0] tb_wdata;
    assign dbus = tb_drive ? tb_wdata : 32'bz;

    intr_ctrl #(.BITS(BITS), .BASE(BASE), .NSRC(NSRC)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .dbus_io (dbus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    bit m_pend [NSRC];
    bit m_mask [NSRC];
    bit m_prev [NSRC];
    bit m_gie;
    bit m_waiting;
    bit m_serving;
    int m_id;
    int m_ivec;
    int m_isrid;

    function automatic int pack(input bit v [NSRC]);
        int r = 0;
        for (int i = 0; i < NSRC; i++) if (v[i]) r += (1 << i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_pend[i] = 1'b0; m_mask[i] = 1'b0; m_prev[i] = 1'b0;
        end
        m_gie = 1'b0; m_waiting = 1'b0; m_serving = 1'b0;
        m_id = 0; m_ivec = 0; m_isrid = 0;
    endtask

    // Advance one clock; the model evaluates the inputs present at the edge.
    task automatic cycle();
        bit n_pend [NSRC];
        bit n_mask [NSRC];
        bit n_prev [NSRC];
        bit n_gie, n_waiting, n_serving, wr, wp, wm, wc;
        int n_id, n_ivec, n_isrid, cand, acked;
        wr = bus.we && !bus.flush;
        wp = wr && (bus.abus == A_PEND);
        wm = wr && (bus.abus == A_MASK);
        wc = wr && (bus.abus == A_CTRL);
        cand = -1;
        for (int i = 0; i < NSRC; i++)
            if (cand < 0 && m_pend[i] && m_mask[i]) cand = i;
        n_waiting = m_waiting; n_serving = m_serving;
        n_id = m_id; n_ivec = m_ivec; n_isrid = m_isrid; acked = -1;
        if (m_waiting) begin
            if (!m_pend[m_id] || !m_mask[m_id] || !m_gie) begin
                n_waiting = 1'b0;
            end else if (bus.inta) begin
                n_waiting = 1'b0; n_serving = 1'b1;
                n_ivec = m_id; n_isrid = 16 + m_id; acked = m_id;
            end
        end else if (m_serving) begin
            if (wc && tb_wdata[1]) begin
                n_serving = 1'b0; n_isrid = 0;
            end
        end else if (m_gie && cand >= 0) begin
            n_waiting = 1'b1; n_id = cand;
        end
        for (int i = 0; i < NSRC; i++) begin
            n_pend[i] = (bus.src[i] && !m_prev[i]) ||
                        (m_pend[i] && !(wp && tb_wdata[i]) && acked != i);
            n_mask[i] = wm ? tb_wdata[i] : m_mask[i];
            n_prev[i] = bus.src[i];
        end
        n_gie = wc ? tb_wdata[0] : m_gie;
        @(posedge clk);
        #1;
        m_pend = n_pend; m_mask = n_mask; m_prev = n_prev; m_gie = n_gie;
        m_waiting = n_waiting; m_serving = n_serving;
        m_id = n_id; m_ivec = n_ivec; m_isrid = n_isrid;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.abus = a; bus.we = 1'b0; bus.flush = 1'b0; tb_drive = 1'b0;
        #1;
        d = dbus;
        bus.abus = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.abus = a; bus.we = 1'b1; bus.flush = 1'b0;
        tb_drive = 1'b1; tb_wdata = d;
        cycle();
        bus.we = 1'b0; tb_drive = 1'b0; bus.abus = 32'd0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.abus = 32'd0; bus.we = 1'b0; bus.flush = 1'b0;
        bus.src = 4'd0; bus.inta = 1'b0;
        tb_drive = 1'b0; tb_wdata = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
        checks++; if (bus.ivec !== 4'd0) begin errors++; $display("FAIL reset_ivec: got %h expected 0", bus.ivec); end
        rd(A_PEND, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pend: got %h expected 0", d); end
        rd(A_MASK, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h expected 0", d); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        rd(A_ISRID, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_isrid: got %h expected 0", d); end
        bus.abus = BASE + 32'd16; #1;
        checks++; if (dbus !== RELEASED) begin errors++; $display("FAIL unmapped_read_z: got %h expected released bus", dbus); end
        bus.abus = 32'd0;
    endtask

    task automatic test_basic_flow();
        logic [31:0] d;
        int n;
        apply_reset();
        bus_write(A_MASK, 32'h4);
        bus_write(A_CTRL, 32'h1);
        bus.src = 4'b0100; cycle(); bus.src = 4'b0000;
        rd(A_PEND, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL basic_pend: got %h expected 4", d); end
        n = 1;
        while (!bus.irq && n < 6) begin cycle(); n++; end
        checks++; if (bus.irq !== 1'b1 || n > 2) begin errors++; $display("FAIL basic_irq_latency: irq %b after %0d cycles expected 1 within 2", bus.irq, n); end
        bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL basic_ack_irq: got %b expected 0", bus.irq); end
        checks++; if (bus.ivec !== 4'd2) begin errors++; $display("FAIL basic_ivec: got %h expected 2", bus.ivec); end
        rd(A_ISRID, d);
        checks++; if (d !== 32'h12) begin errors++; $display("FAIL basic_isrid: got %h expected 12", d); end
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_cleared: got %h expected 0", d); end
        bus_write(A_CTRL, 32'h3);
        rd(A_ISRID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_eoi_isrid: got %h expected 0", d); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_ctrl_read: got %h expected 1", d); end
        checks++; if (bus.ivec !== 4'd2) begin errors++; $display("FAIL basic_ivec_hold: got %h expected 2", bus.ivec); end
    endtask

    task automatic test_priority();
        int n;
        apply_reset();
        bus_write(A_MASK, 32'hF);
        bus_write(A_CTRL, 32'h1);
        bus.src = 4'b1010; cycle(); bus.src = 4'b0000;
        n = 0;
        while (!bus.irq && n < 5) begin cycle(); n++; end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL prio_irq1: got %b expected 1", bus.irq); end
        bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
        checks++; if (bus.ivec !== 4'd1) begin errors++; $display("FAIL prio_ivec1: got %h expected 1", bus.ivec); end
        bus_write(A_CTRL, 32'h3);
        n = 0;
        while (!bus.irq && n < 5) begin cycle(); n++; end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL prio_irq2: got %b expected 1", bus.irq); end
        bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
        checks++; if (bus.ivec !== 4'd3) begin errors++; $display("FAIL prio_ivec2: got %h expected 3", bus.ivec); end
        bus_write(A_CTRL, 32'h3);
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        int n;
        apply_reset();
        bus_write(A_MASK, 32'h4);
        bus_write(A_CTRL, 32'h1);
        bus.src = 4'b0100; cycle(); bus.src = 4'b0000;
        n = 0;
        while (!bus.irq && n < 5) begin cycle(); n++; end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL withdraw_irq_up: got %b expected 1", bus.irq); end
        bus_write(A_MASK, 32'h0);
        // Withdrawal edge: the INTA presented here must be ignored.
        bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL withdraw_irq_drop: got %b expected 0", bus.irq); end
        bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
        checks++; if (bus.ivec !== 4'd0) begin errors++; $display("FAIL withdraw_ivec: got %h expected 0", bus.ivec); end
        rd(A_ISRID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL withdraw_isrid: got %h expected 0", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        apply_reset();
        bus.src = 4'b0001;
        bus_write(A_PEND, 32'h1);
        rd(A_PEND, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL collision_set_wins: got %h expected 1", d); end
        bus.abus = A_PEND; bus.we = 1'b0; bus.flush = 1'b1; #1;
        checks++; if (dbus !== RELEASED) begin errors++; $display("FAIL flush_read_z: got %h expected released bus", dbus); end
        bus.we = 1'b1; tb_drive = 1'b1; tb_wdata = 32'h1;
        cycle();
        bus.we = 1'b0; tb_drive = 1'b0; bus.flush = 1'b0; bus.abus = 32'd0;
        rd(A_PEND, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_write_ignored: got %h expected 1", d); end
        bus_write(A_PEND, 32'hFFFF_FFFF);
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL steady_high_no_reset: got %h expected 0", d); end
        bus.src = 4'b0000;
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        int n;
        apply_reset();
        bus_write(A_MASK, 32'h3);
        bus_write(A_CTRL, 32'h1);
        bus.src = 4'b0010;
        n = 0;
        while (!bus.irq && n < 5) begin cycle(); n++; end
        bus.inta = 1'b1; cycle(); bus.inta = 1'b0;
        checks++; if (bus.ivec !== 4'd1) begin errors++; $display("FAIL mid_service_ivec: got %h expected 1", bus.ivec); end
        bus.src = 4'b0100; cycle();
        #2;
        rst = 1'b1; bus.src = 4'b0001; model_reset();
        #1;
        checks++; if (bus.irq !== 1'b0 || bus.ivec !== 4'd0) begin errors++; $display("FAIL async_reset_outs: got irq %b ivec %h expected 0 0", bus.irq, bus.ivec); end
        rd(A_ISRID, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_reset_isrid: got %h expected 0", d); end
        rd(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_reset_pend: got %h expected 0", d); end
        rd(A_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_reset_mask: got %h expected 0", d); end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        rd(A_PEND, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL release_high_src: got %h expected 1", d); end
        bus.src = 4'b0000;
    endtask

    task automatic test_random();
        logic [31:0] d;
        int op;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) bus.src = 4'($urandom);
            bus.inta = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 11);
            case (op)
                0: bus_write(A_PEND, $urandom);
                1: bus_write(A_MASK, $urandom);
                2, 3: bus_write(A_CTRL, {30'd0, 1'($urandom), ($urandom_range(0, 3) != 0)});
                4: bus_write(BASE + 32'd16, $urandom);
                5: begin
                    bus.abus = A_MASK; bus.we = 1'b1; bus.flush = 1'b1;
                    tb_drive = 1'b1; tb_wdata = $urandom;
                    cycle();
                    bus.we = 1'b0; bus.flush = 1'b0; tb_drive = 1'b0; bus.abus = 32'd0;
                end
                default: cycle();
            endcase
            bus.inta = 1'b0;
            checks++; if (bus.irq !== m_waiting) begin errors++; $display("FAIL rand_irq c=%0d: got %b expected %b", c, bus.irq, m_waiting); end
            checks++; if (bus.ivec !== 4'(m_ivec)) begin errors++; $display("FAIL rand_ivec c=%0d: got %h expected %h", c, bus.ivec, m_ivec); end
            rd(A_PEND, d);
            checks++; if (d !== 32'(pack(m_pend))) begin errors++; $display("FAIL rand_pend c=%0d: got %h expected %h", c, d, pack(m_pend)); end
            rd(A_MASK, d);
            checks++; if (d !== 32'(pack(m_mask))) begin errors++; $display("FAIL rand_mask c=%0d: got %h expected %h", c, d, pack(m_mask)); end
            rd(A_ISRID, d);
            checks++; if (d !== 32'(m_isrid)) begin errors++; $display("FAIL rand_isrid c=%0d: got %h expected %h", c, d, m_isrid); end
            rd(A_CTRL, d);
            checks++; if (d !== 32'(m_gie)) begin errors++; $display("FAIL rand_ctrl c=%0d: got %h expected %h", c, d, m_gie); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.abus = 32'd0; bus.we = 1'b0; bus.flush = 1'b0;
        bus.src = 4'd0; bus.inta = 1'b0;
        tb_drive = 1'b0; tb_wdata = 32'd0;
        test_reset();
        test_basic_flow();
        test_priority();
        test_withdraw();
        test_collision();
        test_reset_mid_service();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
